// File: rtl/ira_ldpc_encoder_if.sv
`default_nettype none
// ============================================================================
// ira_ldpc_encoder_if : info-bit input and coded-bit output stream handshakes
// Rev 1.0
// ============================================================================
interface ira_ldpc_encoder_if;
  logic din;
  logic din_valid;
  logic din_ready;
  logic dout;
  logic dout_valid;
  logic dout_ready;
  logic dout_last;

  modport master (
    output din, din_valid, dout_ready,
    input  din_ready, dout, dout_valid, dout_last
  );

  modport slave (
    input  din, din_valid, dout_ready,
    output din_ready, dout, dout_valid, dout_last
  );
endinterface
`default_nettype wire

// File: rtl/ira_ldpc_encoder.sv
`default_nettype none
// ============================================================================
// ira_ldpc_encoder : systematic IRA/QC-LDPC encoder, ROM-addressed parity
// accumulation then XOR-accumulated parity stream. IRA_ENC_FRAME_CNT_EN adds frame_cnt.
// Rev 1.0
// ============================================================================
module ira_ldpc_encoder #(
  parameter int K  = 4320,
  parameter int Z  = 360,
  parameter int M  = 4320,
  parameter int W  = 13,
  parameter int AW = $clog2(M),
  parameter int GW = $clog2(K/Z)
) (
  input  wire logic                  clk,
  input  wire logic                  rst_n,
  input  wire logic                  done_rst,
  ira_ldpc_encoder_if.slave          bus,
  output logic                       encode_busy,
  output logic                       tbl_rd,
  output logic [GW-1:0]              tbl_addr,
  input  wire logic [W*(AW+1)-1:0]   tbl_data
`ifdef IRA_ENC_FRAME_CNT_EN
  ,
  output logic [15:0]                frame_cnt
`endif
);

  localparam int Q  = M / Z;
  localparam int NG = K / Z;
  localparam int JW = (Z > 1) ? $clog2(Z) : 1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_WAIT  = 3'd2,
    ST_INFO  = 3'd3,
    ST_PAR   = 3'd4
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [GW-1:0]          r_g;
  logic [JW-1:0]          r_j;
  logic [AW-1:0]          r_pidx;
  logic                   r_acc;
  logic [W-1:0][AW-1:0]   r_addr;
  logic [W-1:0]           r_vld;
  logic [M-1:0]           r_parity;

  logic [M-1:0]           w_toggle;
  logic [W-1:0][AW:0]     w_sum;
  logic [W-1:0][AW-1:0]   w_addr_nxt;
  logic                   w_in_xfer;
  logic                   w_par_xfer;
  logic                   w_grp_end;
  logic                   w_last_grp;
  logic                   w_pidx_last;
  logic                   w_pbit;

  assign w_in_xfer   = (r_state == ST_INFO) && bus.din_valid && bus.dout_ready && !done_rst;
  assign w_par_xfer  = (r_state == ST_PAR) && bus.dout_ready && !done_rst;
  assign w_grp_end   = w_in_xfer && (r_j == JW'(Z-1));
  assign w_last_grp  = (r_g == GW'(NG-1));
  assign w_pidx_last = (r_pidx == AW'(M-1));
  assign w_pbit      = r_acc ^ r_parity[r_pidx];

  // Each occurrence of an address flips its bit, so duplicate entries cancel pairwise.
  always_comb begin
    w_toggle = '0;
    for (int w = 0; w < W; w++) begin
      if (r_vld[w]) begin
        w_toggle[r_addr[w]] = ~w_toggle[r_addr[w]];
      end
    end
  end

  always_comb begin
    w_sum      = '0;
    w_addr_nxt = '0;
    for (int w = 0; w < W; w++) begin
      w_sum[w] = {1'b0, r_addr[w]} + (AW+1)'(Q);
      if (w_sum[w] >= (AW+1)'(M)) begin
        w_addr_nxt[w] = AW'(w_sum[w] - (AW+1)'(M));
      end else begin
        w_addr_nxt[w] = w_sum[w][AW-1:0];
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (bus.din_valid) w_state_nxt = ST_FETCH;
      ST_FETCH: w_state_nxt = ST_WAIT;
      ST_WAIT:  w_state_nxt = ST_INFO;
      ST_INFO:  if (w_grp_end) w_state_nxt = w_last_grp ? ST_PAR : ST_FETCH;
      ST_PAR:   if (w_par_xfer && w_pidx_last) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
    if (done_rst) begin
      w_state_nxt = ST_IDLE;
    end
  end

  always_comb begin
    bus.din_ready  = 1'b0;
    bus.dout       = 1'b0;
    bus.dout_valid = 1'b0;
    bus.dout_last  = 1'b0;
    tbl_rd         = 1'b0;
    case (r_state)
      ST_FETCH: tbl_rd = 1'b1;
      ST_INFO: begin
        bus.din_ready  = bus.dout_ready;
        bus.dout       = bus.din;
        bus.dout_valid = bus.din_valid;
      end
      ST_PAR: begin
        bus.dout       = w_pbit;
        bus.dout_valid = 1'b1;
        bus.dout_last  = w_pidx_last;
      end
      default: ;
    endcase
    // An abort cycle must not complete a transfer or flag a frame end.
    if (done_rst) begin
      bus.din_ready  = 1'b0;
      bus.dout_valid = 1'b0;
      bus.dout_last  = 1'b0;
    end
  end

  assign encode_busy = (r_state != ST_IDLE);
  assign tbl_addr    = r_g;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_g      <= '0;
      r_j      <= '0;
      r_pidx   <= '0;
      r_acc    <= 1'b0;
      r_addr   <= '0;
      r_vld    <= '0;
      r_parity <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (done_rst || (r_state == ST_IDLE)) begin
        r_g      <= '0;
        r_j      <= '0;
        r_pidx   <= '0;
        r_acc    <= 1'b0;
        r_parity <= '0;
      end else begin
        case (r_state)
          ST_WAIT: begin
            for (int w = 0; w < W; w++) begin
              r_vld[w]  <= tbl_data[w*(AW+1)+AW];
              r_addr[w] <= tbl_data[w*(AW+1) +: AW];
            end
          end
          ST_INFO: begin
            if (w_in_xfer) begin
              if (bus.din) begin
                r_parity <= r_parity ^ w_toggle;
              end
              r_addr <= w_addr_nxt;
              if (w_grp_end) begin
                r_j <= '0;
                if (!w_last_grp) begin
                  r_g <= r_g + GW'(1);
                end
              end else begin
                r_j <= r_j + JW'(1);
              end
            end
          end
          ST_PAR: begin
            if (w_par_xfer) begin
              r_acc  <= w_pbit;
              r_pidx <= r_pidx + AW'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

`ifdef IRA_ENC_FRAME_CNT_EN
  logic [15:0] r_frame_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame_cnt <= '0;
    end else if (w_par_xfer && w_pidx_last) begin
      r_frame_cnt <= r_frame_cnt + 16'd1;
    end
  end

  assign frame_cnt = r_frame_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ira_ldpc_encoder.sv
`default_nettype none
// ============================================================================
// tb_ira_ldpc_encoder : directed frames with a queued scoreboard and output monitor
// Rev 1.0
// ============================================================================
module tb_ira_ldpc_encoder;
  localparam int K  = 4;
  localparam int Z  = 2;
  localparam int M  = 4;
  localparam int W  = 2;
  localparam int AW = 2;
  localparam int GW = 1;
  localparam int EW = AW + 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              done_rst = 1'b0;
  logic              encode_busy;
  logic              tbl_rd;
  logic [GW-1:0]     tbl_addr;
  logic [W*EW-1:0]   tbl_data = '0;
  logic [W*EW-1:0]   rom [2];
`ifdef IRA_ENC_FRAME_CNT_EN
  logic [15:0]       frame_cnt;
`endif

  ira_ldpc_encoder_if bus ();

  ira_ldpc_encoder #(
    .K(K), .Z(Z), .M(M), .W(W), .AW(AW), .GW(GW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .done_rst    (done_rst),
    .bus         (bus),
    .encode_busy (encode_busy),
    .tbl_rd      (tbl_rd),
    .tbl_addr    (tbl_addr),
    .tbl_data    (tbl_data)
`ifdef IRA_ENC_FRAME_CNT_EN
    ,
    .frame_cnt   (frame_cnt)
`endif
  );

  int         checks = 0;
  int         errors = 0;
  logic [1:0] exp_q [$];   // {dout, dout_last}
  logic [1:0] exp_e;
  logic       bp_en = 1'b0;
  int         bp_idx = 0;
  logic       stab_en = 1'b0;
  logic       prev_stall = 1'b0;
  logic       prev_dout = 1'b0;

  always #5 clk = ~clk;

  // Registered ROM: data appears the cycle after the read strobe.
  always @(posedge clk) begin
    if (tbl_rd) tbl_data <= rom[tbl_addr];
  end

  function automatic logic [EW-1:0] ent(input logic v, input int b);
    return {v, AW'(b)};
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (stab_en && prev_stall)
        chk("stall_hold", {6'd0, bus.dout_valid, bus.dout}, {6'd0, 1'b1, prev_dout});
      if (stab_en && !bus.dout_ready && encode_busy)
        chk("stall_no_din", {7'd0, bus.din_ready}, 8'd0);
      prev_stall = bus.dout_valid && !bus.dout_ready;
      prev_dout  = bus.dout;
      if (bus.dout_valid && bus.dout_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out actual=%0b required=none", {bus.dout, bus.dout_last});
        end else begin
          exp_e = exp_q.pop_front();
          chk("dout_last", {6'd0, bus.dout, bus.dout_last}, {6'd0, exp_e});
        end
      end
    end
  end

  initial begin
    bus.dout_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (bp_en) begin
        bus.dout_ready = ((bp_idx % 4) == 0) || ((bp_idx % 4) == 3);
        bp_idx++;
      end else begin
        bus.dout_ready = 1'b1;
      end
    end
  end

  task automatic send_bit(input logic b);
    int n;
    n = 0;
    bus.din       = b;
    bus.din_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (bus.din_ready) break;
      n++;
      if (n > 200) begin
        checks++;
        errors++;
        $display("FAIL din_accept_timeout actual=0 required=1");
        break;
      end
    end
    @(posedge clk);
    #1;
    bus.din_valid = 1'b0;
    bus.din       = 1'b0;
  endtask

  task automatic wait_empty(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain actual=%0d required=0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic push_frame(input logic [3:0] sys, input logic [3:0] par, input int npar);
    for (int i = 0; i < 4; i++) exp_q.push_back({sys[3-i], 1'b0});
    for (int i = 0; i < npar; i++) exp_q.push_back({par[3-i], (i == 3) ? 1'b1 : 1'b0});
  endtask

  task automatic run_frame(input string name, input logic [3:0] sys, input logic [3:0] par);
    push_frame(sys, par, 4);
    for (int i = 0; i < 4; i++) send_bit(sys[3-i]);
    wait_empty(name);
    chk({name, "_busy_end"}, {7'd0, encode_busy}, 8'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    bus.din       = 1'b0;
    bus.din_valid = 1'b0;
    rom[0] = {ent(1'b0, 0), ent(1'b1, 1)};
    rom[1] = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", {1'b0, bus.din_ready, bus.dout, bus.dout_valid, bus.dout_last,
                          encode_busy, tbl_rd, tbl_addr}, 8'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("idle_outputs", {1'b0, bus.din_ready, bus.dout, bus.dout_valid, bus.dout_last,
                         encode_busy, tbl_rd, tbl_addr}, 8'd0);
    @(posedge clk);
    #1;

    run_frame("zeros",      4'b0000, 4'b0000);
    run_frame("single_hit", 4'b1000, 4'b0111);

    rom[0] = {ent(1'b1, 1), ent(1'b1, 1)};
    run_frame("dup_cancel", 4'b1000, 4'b0000);

    rom[0] = {ent(1'b0, 0), ent(1'b1, 3)};
    run_frame("addr_wrap",  4'b0100, 4'b0111);

    rom[0] = '0;
    rom[1] = {ent(1'b0, 0), ent(1'b1, 0)};
    run_frame("group1_hit", 4'b0010, 4'b1111);

    rom[0] = {ent(1'b0, 0), ent(1'b1, 1)};
    rom[1] = '0;
    bp_en = 1'b1;
    stab_en = 1'b1;
    run_frame("backpressure_a", 4'b1000, 4'b0111);
    run_frame("backpressure_b", 4'b1000, 4'b0111);
    bp_en = 1'b0;
    stab_en = 1'b0;
    @(posedge clk);
    #1;

    // Abort one bit into the first group, then a clean frame must match exactly.
    exp_q.push_back(2'b10);
    send_bit(1'b1);
    done_rst = 1'b1;
    @(posedge clk);
    #1 done_rst = 1'b0;
    @(negedge clk);
    chk("busy_after_abort", {7'd0, encode_busy}, 8'd0);
    chk("abort_pending", 8'(exp_q.size()), 8'd0);
    @(posedge clk);
    #1;
    run_frame("after_abort", 4'b1000, 4'b0111);

    // Reset after two parity bits have left.
    push_frame(4'b1000, 4'b0111, 2);
    for (int i = 0; i < 4; i++) send_bit((i == 0) ? 1'b1 : 1'b0);
    wait_empty("par_abort");
    chk("busy_mid_par", {7'd0, encode_busy}, 8'd1);
    rst_n = 1'b0;
    #1;
    chk("reset_mid_par", {1'b0, bus.din_ready, bus.dout, bus.dout_valid, bus.dout_last,
                          encode_busy, tbl_rd, tbl_addr}, 8'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_frame("after_reset", 4'b1000, 4'b0111);

    repeat (3) @(posedge clk);
    chk("no_extra_out", 8'(exp_q.size()), 8'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
